vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Parametrised video timing generator plus test-pattern source; successor to the fixed 640x480 timing and colorbar pair.
- Produces hsync, vsync and data-enable with programmable porches and sync polarity.
- Outputs RGB888 directly, so no 565-to-888 expansion is needed ahead of the TMDS encoder.
- Four patterns are selectable at run time; a new selection takes effect only on a frame boundary. Sits between the PLL pixel clock and the HDMI encoder.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, active lines
- V_FRONT, 10, vertical front porch
- SYNC_POL, 0, asserted sync level; 0 means active-low
- GRID, 32, grid pitch in pixels for mode 2; must be at least 2
- CNT_W, 12, width of the counters and of pix_x/pix_y

Ports:
- vga_clk  in  1  pixel clock
- sys_rst  in  1  synchronous reset, active-high
- mode_sel  in  2  pattern select: 0 colorbar, 1 gray ramp, 2 grid, 3 solid
- solid_rgb  in  24  colour used in mode 3, {R,G,B}
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- rgb_valid  out  1  data enable, high during active pixels
- pix_x  out  CNT_W  active column; 0 when rgb_valid=0
- pix_y  out  CNT_W  active row; 0 when rgb_valid=0
- rgb_red  out  8  red channel
- rgb_green  out  8  green channel
- rgb_blue  out  8  blue channel
- frame_start  out  1  one-cycle pulse, aligned with the first output cycle of each frame

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise for the vertical parameters.
- Horizontal counter h_cnt runs 0..H_TOTAL-1 and wraps to 0.
- Vertical counter v_cnt increments only when h_cnt wraps; it runs 0..V_TOTAL-1 and wraps to 0.
- Regions:
  - Sync: h_cnt < H_SYNC (horizontal), v_cnt < V_SYNC (vertical).
  - Active: HA0 <= h_cnt < HA0+H_ACTIVE, where HA0 = H_SYNC+H_BACK, and VA0 <= v_cnt < VA0+V_ACTIVE, where VA0 = V_SYNC+V_BACK.
- Sync levels: hsync = SYNC_POL inside the horizontal sync region, else ~SYNC_POL. vsync uses the same rule on v_cnt.
- Latency: every output is registered, exactly 1 cycle after the counter state that produces it. All outputs are mutually aligned.
- pix_x = h_cnt-HA0 and pix_y = v_cnt-VA0 when active. rgb and pix are 0 whenever rgb_valid = 0.
- Mode latch:
  - mode_sel and solid_rgb are sampled into mode_r and solid_r when h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
  - The latched values apply from the next frame onward.
  - Mid-frame changes on the inputs have no effect on the frame in progress.
- Mode 0, colorbar:
  - 8 vertical bars, each H_ACTIVE/8 pixels wide. The bar index comes from a pixel counter that resets at the start of active video; no divider.
  - Colour order left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Mode 1, gray ramp: R = G = B = pix_x[7:0], wrapping every 256 pixels.
- Mode 2, grid:
  - Output FFFFFF when the x-phase counter is 0 or the y-phase counter is 0; otherwise 000000.
  - Both phase counters count 0..GRID-1 and reset at the start of active line (x) and active frame (y). No modulo operator.
- Mode 3, solid: output = solid_r during active pixels.
- frame_start is high on the output cycle corresponding to h_cnt = 0, v_cnt = 0.
- Reset:
  - Counters 0, mode_r = 0, solid_r = 0.
  - hsync = vsync = ~SYNC_POL, rgb_valid = 0, pix = 0, rgb = 0, frame_start = 0.
  - The first cycle after reset deasserts evaluates h_cnt = v_cnt = 0. Its outputs appear one cycle later: frame_start = 1, hsync and vsync asserted.
- Reset asserted mid-frame: on the next edge, counters and mode_r return to reset values and outputs go to reset levels. The following frame restarts cleanly, with no partial-line carry-over.
- Simultaneous wraps: when h_cnt and v_cnt both wrap on the same cycle, the frame restarts and the mode latch update occurs on that same edge.

Test Plan:
- Release reset, defaults -> at output cycle 1 frame_start = 1 and hsync = vsync = 0. hsync is low for 96 cycles of every 800. vsync is low for 2 lines of 525. rgb_valid is high for 640x480 pixels per frame.
- Mode 0 -> on the first active line, pix_x 0..79 gives FFFFFF, 80..159 gives FFFF00, and 560..639 gives 000000. rgb_valid rises at h_cnt output cycle 145 (HA0 = 144, plus 1 latency).
- Mode 1 -> pix_x = 255 gives rgb = FFFFFF; pix_x = 256 gives 000000; pix_x = 639 gives 7F7F7F.
- Mode 2 with GRID=32 -> pixel (0,5) white, (32,5) white, (5,64) white, (5,5) black.
- Switch mode_sel 0->3 with solid_rgb = 123456 mid-frame -> the rest of that frame remains colorbar. The next frame is entirely 123456 on every active pixel.
- SYNC_POL=1 with a small geometry (H 2/2/8/2, V 1/1/4/1) -> hsync is high 2 of 14 cycles. Asserting sys_rst at pixel (3,2) makes outputs return to their reset levels on the next cycle. Deasserting it gives frame_start one cycle later.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised video timing generator with four test patterns.
// Ports: vga_clk/sys_rst (sync, active-high); mode_sel, solid_rgb pattern
// controls (latched at frame end); hsync, vsync, rgb_valid, pix_x, pix_y,
// rgb_red/green/blue, frame_start, all registered one cycle after counters.
module vga_pattern_gen #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int SYNC_POL = 0,
   parameter int GRID     = 32,
   parameter int CNT_W    = 12
) (
   input  logic             vga_clk,
   input  logic             sys_rst,
   input  logic [1:0]       mode_sel,
   input  logic [23:0]      solid_rgb,
   output logic             hsync,
   output logic             vsync,
   output logic             rgb_valid,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic [7:0]       rgb_red,
   output logic [7:0]       rgb_green,
   output logic [7:0]       rgb_blue,
   output logic             frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HA0     = H_SYNC + H_BACK;
   localparam int VA0     = V_SYNC + V_BACK;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [CNT_W-1:0] C_H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_HS       = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] C_VS       = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] C_HA0      = CNT_W'(HA0);
   localparam logic [CNT_W-1:0] C_HA1      = CNT_W'(HA0 + H_ACTIVE);
   localparam logic [CNT_W-1:0] C_VA0      = CNT_W'(VA0);
   localparam logic [CNT_W-1:0] C_VA1      = CNT_W'(VA0 + V_ACTIVE);
   localparam logic [CNT_W-1:0] C_HA_LAST  = CNT_W'(HA0 + H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] C_VA_LAST  = CNT_W'(VA0 + V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] C_BAR_LAST = CNT_W'(BAR_W - 1);
   localparam logic [CNT_W-1:0] C_G_LAST   = CNT_W'(GRID - 1);
   localparam logic             C_POL      = (SYNC_POL != 0);

   logic [CNT_W-1:0] r_h_cnt;
   logic [CNT_W-1:0] r_v_cnt;
   logic [CNT_W-1:0] r_bar_px;
   logic [2:0]       r_bar_idx;
   logic [CNT_W-1:0] r_gx;
   logic [CNT_W-1:0] r_gy;
   logic [1:0]       r_mode;
   logic [23:0]      r_solid;

   logic             w_h_wrap;
   logic             w_v_wrap;
   logic             w_h_act;
   logic             w_v_act;
   logic             w_act;
   logic [CNT_W-1:0] w_px;
   logic [CNT_W-1:0] w_py;
   logic [23:0]      w_bar;
   logic [23:0]      w_rgb;

   assign w_h_wrap = (r_h_cnt == C_H_LAST);
   assign w_v_wrap = (r_v_cnt == C_V_LAST);
   assign w_h_act  = (r_h_cnt >= C_HA0) && (r_h_cnt < C_HA1);
   assign w_v_act  = (r_v_cnt >= C_VA0) && (r_v_cnt < C_VA1);
   assign w_act    = w_h_act && w_v_act;
   assign w_px     = r_h_cnt - C_HA0;
   assign w_py     = r_v_cnt - C_VA0;

   // Bar and grid phase counters track the current counter state; they sit
   // at 0 outside active video so the first active pixel/line starts at 0.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         r_h_cnt   <= '0;
         r_v_cnt   <= '0;
         r_bar_px  <= '0;
         r_bar_idx <= '0;
         r_gx      <= '0;
         r_gy      <= '0;
         r_mode    <= '0;
         r_solid   <= '0;
      end else begin
         r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
         if (w_h_wrap) begin
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
         end
         if (w_h_act && (r_h_cnt != C_HA_LAST)) begin
            if (r_bar_px == C_BAR_LAST) begin
               r_bar_px  <= '0;
               r_bar_idx <= r_bar_idx + 1'b1;
            end else begin
               r_bar_px <= r_bar_px + 1'b1;
            end
            r_gx <= (r_gx == C_G_LAST) ? '0 : r_gx + 1'b1;
         end else begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
            r_gx      <= '0;
         end
         if (w_h_wrap) begin
            if (w_v_act && (r_v_cnt != C_VA_LAST)) begin
               r_gy <= (r_gy == C_G_LAST) ? '0 : r_gy + 1'b1;
            end else begin
               r_gy <= '0;
            end
         end
         if (w_h_wrap && w_v_wrap) begin
            r_mode  <= mode_sel;
            r_solid <= solid_rgb;
         end
      end
   end

   always_comb begin
      w_bar = 24'h000000;
      unique case (r_bar_idx)
         3'd0: w_bar = 24'hFFFFFF;
         3'd1: w_bar = 24'hFFFF00;
         3'd2: w_bar = 24'h00FFFF;
         3'd3: w_bar = 24'h00FF00;
         3'd4: w_bar = 24'hFF00FF;
         3'd5: w_bar = 24'hFF0000;
         3'd6: w_bar = 24'h0000FF;
         3'd7: w_bar = 24'h000000;
      endcase
      w_rgb = 24'h000000;
      if (w_act) begin
         unique case (r_mode)
            2'd0: w_rgb = w_bar;
            2'd1: w_rgb = {3{w_px[7:0]}};
            2'd2: w_rgb = ((r_gx == '0) || (r_gy == '0)) ? 24'hFFFFFF : 24'h000000;
            2'd3: w_rgb = r_solid;
         endcase
      end
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         hsync       <= ~C_POL;
         vsync       <= ~C_POL;
         rgb_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         rgb_red     <= '0;
         rgb_green   <= '0;
         rgb_blue    <= '0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (r_h_cnt < C_HS) ? C_POL : ~C_POL;
         vsync       <= (r_v_cnt < C_VS) ? C_POL : ~C_POL;
         rgb_valid   <= w_act;
         pix_x       <= w_act ? w_px : '0;
         pix_y       <= w_act ? w_py : '0;
         rgb_red     <= w_rgb[23:16];
         rgb_green   <= w_rgb[15:8];
         rgb_blue    <= w_rgb[7:0];
         frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: two geometries, random pattern changes
// and resets, expected outputs from an arithmetic reference model.
module tb_vga_pattern_gen;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] x;
      logic [11:0] y;
      logic [23:0] rgb;
      logic        fs;
   } o_t;

   bit          clk = 1'b0;
   logic        rst_a;
   logic        rst_b;
   logic [1:0]  mode_sel;
   logic [23:0] solid;
   bit          rel = 1'b0;

   logic        a_hs, a_vs, a_de, a_fs;
   logic [11:0] a_x, a_y;
   logic [7:0]  a_r, a_g, a_b;
   logic        b_hs, b_vs, b_de, b_fs;
   logic [11:0] b_x, b_y;
   logic [7:0]  b_r, b_g, b_b;

   int checks = 0;
   int errors = 0;

   o_t qa[$];
   o_t qb[$];
   int ta = 0, tb = 0;
   logic [1:0]  ma = 0, mb = 0;
   logic [23:0] sa = 0, sb = 0;

   always #5 clk = ~clk;

   vga_pattern_gen #(
      .H_SYNC(96), .H_BACK(48), .H_ACTIVE(640), .H_FRONT(16),
      .V_SYNC(2), .V_BACK(2), .V_ACTIVE(6), .V_FRONT(1),
      .SYNC_POL(0), .GRID(32), .CNT_W(12)
   ) dut_a (
      .vga_clk(clk), .sys_rst(rst_a), .mode_sel(mode_sel),
      .solid_rgb(solid), .hsync(a_hs), .vsync(a_vs),
      .rgb_valid(a_de), .pix_x(a_x), .pix_y(a_y),
      .rgb_red(a_r), .rgb_green(a_g), .rgb_blue(a_b),
      .frame_start(a_fs)
   );

   vga_pattern_gen #(
      .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
      .SYNC_POL(1), .GRID(2), .CNT_W(12)
   ) dut_b (
      .vga_clk(clk), .sys_rst(rst_b), .mode_sel(mode_sel),
      .solid_rgb(solid), .hsync(b_hs), .vsync(b_vs),
      .rgb_valid(b_de), .pix_x(b_x), .pix_y(b_y),
      .rgb_red(b_r), .rgb_green(b_g), .rgb_blue(b_b),
      .frame_start(b_fs)
   );

   function automatic logic [23:0] bar_col(input int i);
      case (i)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic o_t rst_out(input bit pol);
      o_t o;
      o = '0;
      o.hs = !pol;
      o.vs = !pol;
      return o;
   endfunction

   // Output for the cycle t counter states after reset release.
   function automatic o_t ref_out(
      input int hs, input int hb, input int ha, input int hf,
      input int vs, input int vb, input int va, input int vf,
      input bit pol, input int grid, input int t,
      input logic [1:0] m, input logic [23:0] s);
      o_t o;
      int ht, vt, h, v, px, py;
      logic [7:0] g;
      ht = hs + hb + ha + hf;
      vt = vs + vb + va + vf;
      h = t % ht;
      v = (t / ht) % vt;
      o = '0;
      o.hs = (h < hs) ? pol : !pol;
      o.vs = (v < vs) ? pol : !pol;
      o.fs = (h == 0) && (v == 0);
      if (h >= hs + hb && h < hs + hb + ha && v >= vs + vb && v < vs + vb + va) begin
         px = h - hs - hb;
         py = v - vs - vb;
         o.de = 1'b1;
         o.x = 12'(px);
         o.y = 12'(py);
         g = 8'(px % 256);
         case (m)
            2'd0: o.rgb = bar_col(px / (ha / 8));
            2'd1: o.rgb = {g, g, g};
            2'd2: o.rgb = (px % grid == 0 || py % grid == 0) ? 24'hFFFFFF : 24'h0;
            default: o.rgb = s;
         endcase
      end
      return o;
   endfunction

   always @(posedge clk) begin
      if (rst_a) begin
         qa.push_back(rst_out(1'b0));
         ta = 0; ma = 0; sa = 0;
      end else begin
         qa.push_back(ref_out(96, 48, 640, 16, 2, 2, 6, 1, 1'b0, 32, ta, ma, sa));
         if (ta % (800 * 11) == 800 * 11 - 1) begin
            ma = mode_sel; sa = solid;
         end
         ta++;
      end
      if (rst_b) begin
         qb.push_back(rst_out(1'b1));
         tb = 0; mb = 0; sb = 0;
      end else begin
         qb.push_back(ref_out(2, 2, 8, 2, 1, 1, 4, 1, 1'b1, 2, tb, mb, sb));
         if (tb % (14 * 7) == 14 * 7 - 1) begin
            mb = mode_sel; sb = solid;
         end
         tb++;
      end
   end

   always @(negedge clk) begin
      o_t e, g;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         g = '{a_hs, a_vs, a_de, a_x, a_y, {a_r, a_g, a_b}, a_fs};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL dutA t=%0t got hs%b vs%b de%b x%0d y%0d rgb%h fs%b exp hs%b vs%b de%b x%0d y%0d rgb%h fs%b",
                     $time, g.hs, g.vs, g.de, g.x, g.y, g.rgb, g.fs,
                     e.hs, e.vs, e.de, e.x, e.y, e.rgb, e.fs);
         end
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         g = '{b_hs, b_vs, b_de, b_x, b_y, {b_r, b_g, b_b}, b_fs};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL dutB t=%0t got hs%b vs%b de%b x%0d y%0d rgb%h fs%b exp hs%b vs%b de%b x%0d y%0d rgb%h fs%b",
                     $time, g.hs, g.vs, g.de, g.x, g.y, g.rgb, g.fs,
                     e.hs, e.vs, e.de, e.x, e.y, e.rgb, e.fs);
         end
      end
   end

   // Mid-frame resets of the small geometry, first one at pixel (3,2).
   initial begin
      rst_b = 1'b1;
      wait (rel);
      rst_b = 1'b0;
      repeat (63) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      for (int i = 0; i < 100; i++) begin
         repeat ($urandom_range(50, 500)) @(negedge clk);
         rst_b = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         rst_b = 1'b0;
      end
   end

   initial begin
      int c, n;
      rst_a = 1'b1;
      mode_sel = 2'd0;
      solid = 24'h0;
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      rel = 1'b1;
      repeat (3000) @(negedge clk);
      mode_sel = 2'd3;
      solid = 24'h123456;
      repeat (9000) @(negedge clk);
      mode_sel = 2'd1;
      repeat (9000) @(negedge clk);
      mode_sel = 2'd2;
      repeat (9000) @(negedge clk);
      c = 30000;
      while (c < 48000) begin
         n = $urandom_range(300, 4000);
         repeat (n) @(negedge clk);
         c += n;
         mode_sel = 2'($urandom_range(0, 3));
         solid = 24'($urandom);
      end
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      mode_sel = 2'd3;
      repeat (12000) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
